// File: rtl/zero_repair_serializer_pkg.sv
// Shared types and the zero-repair function for zero_repair_serializer.
// Optional statistics ports are enabled with ZREPAIR_STATS_EN.
package zrepair_pkg;

    typedef enum logic {EMPTY, HOLD} win_state_e;
    typedef enum logic {IDLE, SHIFT} ser_state_e;

    localparam int CNT_W = 16;
    // Widest supported word; callers zero-extend and truncate around repair().
    localparam int REP_W = 512;

    function automatic logic [REP_W-1:0] repair(
        input logic [REP_W-1:0] prev,
        input logic [REP_W-1:0] next,
        input logic             prev_vld,
        input logic             next_present
    );
        logic [REP_W:0]   sum;
        logic [REP_W-1:0] res;
        sum = {1'b0, prev} + {1'b0, next};
        unique case ({prev_vld, next_present})
            2'b11:   res = REP_W'(sum >> 1);
            2'b01:   res = next;
            2'b10:   res = prev;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/zero_repair_serializer_if.sv
// Word-in / lane-out valid-ready bundle for zero_repair_serializer.
// slave is the block's view, master the producer/consumer view.
interface zero_repair_serializer_if #(
    parameter int WORD_W = 64,
    parameter int LANE_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_data;
    logic              out_last;
    logic              out_fixed;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_fixed
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_fixed
    );
endinterface

// File: rtl/zero_repair_serializer_ser.sv
// Word-to-lane serialiser, LSB lane first, with gap-free reload on the last lane.
module word_serializer
    import zrepair_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    output logic              load_ok_o,
    input  logic [WORD_W-1:0] word_i,
    input  logic              last_i,
    input  logic              fixed_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [LANE_W-1:0] data_o,
    output logic              last_o,
    output logic              fixed_o
);
    localparam int NL = WORD_W / LANE_W;
    localparam int IW = $clog2(NL);
    localparam logic [IW-1:0] LAST_IDX = IW'(NL - 1);

    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              last_q, last_d;
    logic              fixed_q, fixed_d;
    logic              on_last;

    assign on_last   = (state_q == SHIFT) && (idx_q == LAST_IDX);
    assign load_ok_o = (state_q == IDLE) || (on_last && ready_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            fixed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            fixed_q <= fixed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        last_d  = last_q;
        fixed_d = fixed_q;
        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = SHIFT;
                    word_d  = word_i;
                    idx_d   = '0;
                    last_d  = last_i;
                    fixed_d = fixed_i;
                end
            end
            SHIFT: begin
                if (ready_i) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (load_i) begin
                        word_d  = word_i;
                        idx_d   = '0;
                        last_d  = last_i;
                        fixed_d = fixed_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    assign valid_o = (state_q == SHIFT);
    assign data_o  = valid_o ? word_q[int'(idx_q)*LANE_W +: LANE_W] : '0;
    assign last_o  = on_last && last_q;
    assign fixed_o = valid_o && fixed_q;

endmodule

// File: rtl/zero_repair_serializer.sv
// Zero-word repair window (prev/cur) feeding a lane serialiser.
// ZREPAIR_STATS_EN adds saturating repair_cnt / stream_cnt outputs.
module zero_repair_serializer
    import zrepair_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int LANE_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    zero_repair_serializer_if.slave bus
`ifdef ZREPAIR_STATS_EN
    ,
    output logic [CNT_W-1:0] repair_cnt,
    output logic [CNT_W-1:0] stream_cnt
`endif
);
    win_state_e        win_q, win_d;
    logic [WORD_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic              cur_last_q, cur_last_d;

    logic              cur_vld;
    logic              load_ok;
    logic              in_ready;
    logic              accept;
    logic              resolve;
    logic              cur_zero;
    logic              next_present;
    logic [WORD_W-1:0] rep_word;
    logic [WORD_W-1:0] resolved;

    assign cur_vld  = (win_q == HOLD);
    assign in_ready = !cur_vld || (!cur_last_q && load_ok);
    assign accept   = bus.in_valid && in_ready;
    // A last word has no successor, so it resolves as soon as the serialiser frees up.
    assign resolve  = cur_vld && (cur_last_q ? load_ok : accept);
    assign cur_zero = (cur_q == '0);
    assign next_present = accept && !cur_last_q && (bus.in_data != '0);

    assign rep_word = WORD_W'(repair(REP_W'(prev_q), REP_W'(bus.in_data),
                                     prev_vld_q, next_present));
    assign resolved = cur_zero ? rep_word : cur_q;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q      <= EMPTY;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            cur_q      <= '0;
            cur_last_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            cur_q      <= cur_d;
            cur_last_q <= cur_last_d;
        end
    end

    always_comb begin
        win_d      = win_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        cur_d      = cur_q;
        cur_last_d = cur_last_q;
        unique case (win_q)
            EMPTY: begin
                if (accept) begin
                    cur_d      = bus.in_data;
                    cur_last_d = bus.in_last;
                    win_d      = HOLD;
                end
            end
            HOLD: begin
                if (resolve) begin
                    prev_d     = resolved;
                    prev_vld_d = !cur_last_q;
                    if (accept) begin
                        cur_d      = bus.in_data;
                        cur_last_d = bus.in_last;
                    end else begin
                        win_d = EMPTY;
                    end
                end
            end
        endcase
    end

    word_serializer #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (resolve),
        .load_ok_o (load_ok),
        .word_i    (resolved),
        .last_i    (cur_last_q),
        .fixed_i   (cur_zero),
        .valid_o   (bus.out_valid),
        .ready_i   (bus.out_ready),
        .data_o    (bus.out_data),
        .last_o    (bus.out_last),
        .fixed_o   (bus.out_fixed)
    );

`ifdef ZREPAIR_STATS_EN
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] str_cnt_q;
    logic             stream_done;

    assign stream_done = bus.out_valid && bus.out_ready && bus.out_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt_q <= '0;
            str_cnt_q <= '0;
        end else begin
            if (resolve && cur_zero && (rep_cnt_q != '1)) begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
            end
            if (stream_done && (str_cnt_q != '1)) begin
                str_cnt_q <= str_cnt_q + 1'b1;
            end
        end
    end

    assign repair_cnt = rep_cnt_q;
    assign stream_cnt = str_cnt_q;
`endif

endmodule
